mult_seq_ctrl: RTL
==================

// Module: mult_seq_ctrl
// PURPOSE
//   Moore FSM that sequences the shift-add 4x4 multiplier datapath: operand load,
//     then per multiplier bit an add-or-hold step and a shift step, then completion.
//   Drives the 8-bit partial-product mux select plus the register load/shift enables.
//   Uses a start / done-ack handshake with the issuing logic.
// PARAMETERS
//   WIDTH  4  multiplier width = number of add/shift iterations (legal range 1..15)
//   CNT_W  4  iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous reset, active low
//   start     in   1      request a multiply; sampled only in IDLE, or in DONE together with ack
//   ack       in   1      consumer has taken the product; sampled only in DONE
//   abort     in   1      synchronous cancel of the current operation
//   b_lsb     in   1      current LSB of the datapath multiplier register
//   ld_ab     out  1      load operand registers A and B
//   clr_p     out  1      clear the partial-product register
//   add_sel   out  1      8-bit mux select: 1 = adder sum, 0 = unchanged partial product
//   p_en      out  1      partial-product register write enable
//   shift_en  out  1      shift P right and B right by one bit
//   busy      out  1      high in LOAD, EVAL and SHIFT
//   done      out  1      high in DONE; the product is stable while done is high
// BEHAVIOUR
//   - Reset: rst_n low asynchronously forces IDLE and cnt = 0; every output is 0.
//     Reset asserted mid-operation abandons the operation; no done is produced.
//   - States and outputs (registered state, outputs decoded from state only):
//       IDLE   all outputs 0
//       LOAD   ld_ab = 1, clr_p = 1, busy = 1, cnt <= 0
//       EVAL   p_en = 1, add_sel = b_lsb, busy = 1
//                (add_sel is the only output that depends on an input)
//       SHIFT  shift_en = 1, busy = 1, cnt <= cnt + 1
//       DONE   done = 1
//   - Transitions (evaluated in priority order):
//       1. abort = 1 in LOAD, EVAL or SHIFT -> IDLE; abort is ignored in IDLE and DONE
//       2. IDLE  : start -> LOAD, otherwise stay in IDLE
//       3. LOAD  -> EVAL
//       4. EVAL  -> SHIFT
//       5. SHIFT : cnt == WIDTH-1 -> DONE, otherwise -> EVAL
//       6. DONE  : ack & start -> LOAD (back-to-back); ack & !start -> IDLE;
//                  !ack -> hold in DONE indefinitely
//   - start while busy is ignored and is not queued.
//   - Latency: start sampled at edge 0 -> LOAD in cycle 1 -> alternating EVAL/SHIFT in
//     cycles 2 .. 2*WIDTH+1 -> DONE in cycle 2*WIDTH+2. For WIDTH = 4, done is first
//     high in cycle 10.
//   - Exactly WIDTH EVAL states and WIDTH SHIFT states occur per completed operation.
//   - cnt wraps only through the reload in LOAD; it is never compared outside SHIFT.
//   - b_lsb is don't-care outside EVAL; X on b_lsb must not propagate to any output
//     other than add_sel.
//   - WIDTH = 1: the sequence is LOAD, EVAL, SHIFT, DONE.
// TESTING
//   1. Reset release, start = 0 for 20 cycles -> FSM stays in IDLE, all outputs 0.
//   2. Basic sequence: start pulse with b_lsb sequence 1,0,1,1 in the EVAL cycles
//      -> LOAD in cycle 1; add_sel = 1,0,1,1; 4 shift_en pulses; done from cycle 10.
//      Paired datapath check: 4'd13 x 4'd11 -> product 8'd143.
//   3. Hold ack = 0 for 5 cycles in DONE -> done stays high, no other output toggles;
//      ack = 1 -> IDLE on the next cycle.
//   4. Back-to-back: ack = 1 and start = 1 in the same DONE cycle -> LOAD next cycle;
//      the second operation completes in 2*WIDTH+2 cycles. 15 x 15 -> 8'd225.
//   5. abort in the 2nd SHIFT -> IDLE next cycle, done never asserts.
//      rst_n low in the 3rd EVAL -> all outputs 0 immediately, asynchronously.
//   6. start held high throughout the whole busy period -> no restart and no extra LOAD;
//      re-accepted only in DONE together with ack.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: Moore FSM sequencing a shift-add multiplier datapath
// (load, WIDTH x {add-or-hold, shift}, done) with a start / done-ack handshake.
module mult_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ack,
  input  logic abort,
  input  logic b_lsb,
  output logic ld_ab,
  output logic clr_p,
  output logic add_sel,
  output logic p_en,
  output logic shift_en,
  output logic busy,
  output logic done
);
  typedef enum logic [2:0] {IDLE, LOAD, EVAL, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic ld_q, pen_q, sh_q, busy_q, done_q;
  logic in_op;
  always_comb begin
    in_op = (state_q == LOAD) || (state_q == EVAL) || (state_q == SHIFT);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD : IDLE;
      LOAD:    state_d = EVAL;
      EVAL:    state_d = SHIFT;
      SHIFT:   state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? DONE : EVAL;
      DONE:    state_d = !ack ? DONE : start ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && in_op) state_d = IDLE;
  end
  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      pen_q   <= 1'b0;
      sh_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == LOAD) ? '0 : (state_q == SHIFT) ? cnt_q + CNT_W'(1) : cnt_q;
      ld_q    <= state_d == LOAD;
      pen_q   <= state_d == EVAL;
      sh_q    <= state_d == SHIFT;
      busy_q  <= (state_d == LOAD) || (state_d == EVAL) || (state_d == SHIFT);
      done_q  <= state_d == DONE;
    end
  end
  // Gating with the EVAL flag keeps b_lsb from reaching add_sel in any other state.
  assign add_sel  = pen_q & b_lsb;
  assign ld_ab    = ld_q;
  assign clr_p    = ld_q;
  assign p_en     = pen_q;
  assign shift_en = sh_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule
